logs_r_sequencer: RTL and testbench

//  Schedules the logistic-map sonifier. Owns the growth parameter r and sweeps it by mode. After each r change it

---
 rtl/logs_pkg.sv | 24 ++
 rtl/logs_r_stepper.sv | 67 ++++++
 rtl/logs_r_sequencer.sv | 132 +++++++++++++
 tb/tb_logs_r_sequencer.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/logs_pkg.sv
// Shared definitions for the logistic-map r sequencer.
// Contents:
//   FRAC_DEF, R_MIN_DEF, R_MAX_DEF : default fixed-point width and sweep bounds
//   mode_e                         : sweep mode encodings (sweep-up-wrap, ping-pong, hold, manual)
//   state_e                        : sequencer FSM state encodings (SETTLE, PLAY)
package logs_pkg;

  localparam int FRAC_DEF  = 8;
  localparam int R_MIN_DEF = 'h110;  // r = 1.0625 in 2.8 format
  localparam int R_MAX_DEF = 'h3FF;  // largest 2.8 value below 4.0

  typedef enum logic [1:0] {
    MODE_UP   = 2'b00,
    MODE_PP   = 2'b01,
    MODE_HOLD = 2'b10,
    MODE_MAN  = 2'b11
  } mode_e;

  typedef enum logic {
    ST_SETTLE = 1'b0,
    ST_PLAY   = 1'b1
  } state_e;

endpackage

// File: rtl/logs_r_stepper.sv
// Combinational next-r calculator for the logistic-map sequencer.
// Ports:
//   r        in  FRAC+2  current growth parameter (2.FRAC)
//   dir      in  1       ping-pong direction, 0 = up, 1 = down
//   mode     in  2       sweep mode (logs_pkg::mode_e encoding)
//   r_next   out FRAC+2  r to load on the next update
//   dir_next out 1       direction to load on the next update
module logs_r_stepper
  import logs_pkg::*;
#(
  parameter int FRAC        = FRAC_DEF,
  parameter int R_MIN       = R_MIN_DEF,
  parameter int R_MAX       = R_MAX_DEF,
  parameter int STEP_COARSE = 4,
  parameter int STEP_FINE   = 1
) (
  input  logic [FRAC+1:0] r,
  input  logic            dir,
  input  logic [1:0]      mode,
  output logic [FRAC+1:0] r_next,
  output logic            dir_next
);

  // One extra bit above r so r+s can exceed R_MAX without wrapping.
  localparam int W = FRAC + 3;
  localparam logic [W-1:0] RMIN_W = W'(R_MIN);
  localparam logic [W-1:0] RMAX_W = W'(R_MAX);
  localparam logic [W-1:0] SC_W   = W'(STEP_COARSE);
  localparam logic [W-1:0] SF_W   = W'(STEP_FINE);

  logic [W-1:0] r_w, s_w, up_w, dn_w;

  always_comb begin
    r_w      = {1'b0, r};
    // Fine steps once the integer part of r reaches 3 (chaotic region).
    s_w      = (r[FRAC+1:FRAC] < 2'b11) ? SC_W : SF_W;
    up_w     = r_w + s_w;
    dn_w     = r_w - s_w;
    r_next   = r;
    dir_next = dir;
    case (mode)
      MODE_UP, MODE_MAN: begin
        r_next = (up_w > RMAX_W) ? RMIN_W[FRAC+1:0] : up_w[FRAC+1:0];
      end
      MODE_PP: begin
        if (!dir) begin
          if (up_w > RMAX_W) begin
            dir_next = 1'b1;
            r_next   = dn_w[FRAC+1:0];
          end else begin
            r_next   = up_w[FRAC+1:0];
          end
        end else begin
          // r - s < R_MIN rewritten as r < R_MIN + s to avoid underflow.
          if (r_w < RMIN_W + s_w) begin
            dir_next = 1'b0;
            r_next   = up_w[FRAC+1:0];
          end else begin
            r_next   = dn_w[FRAC+1:0];
          end
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/logs_r_sequencer.sv
// Scheduler for the logistic-map sonifier: owns r, sweeps it by mode, discards
// transient x samples after every r change, then writes accepted x values
// round-robin into the oscillator frequency registers.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   x_ready, x          new map value pulse and value
//   mode                00 sweep-up-wrap, 01 ping-pong, 10 hold, 11 manual
//   step_req            manual r advance pulse (mode 11 only)
//   r                   current growth parameter (2.FRAC)
//   r_changed           pulse in the cycle r takes a new value
//   settling            high while transient samples are being discarded
//   wr_en, wr_idx, wr_x frequency register write port (latency 1 from x_ready)
module logs_r_sequencer
  import logs_pkg::*;
#(
  parameter int FRAC        = FRAC_DEF,
  parameter int N_OSC       = 4,
  parameter int DWELL       = 1000,
  parameter int SETTLE      = 64,
  parameter int R_MIN       = R_MIN_DEF,
  parameter int R_MAX       = R_MAX_DEF,
  parameter int STEP_COARSE = 4,
  parameter int STEP_FINE   = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     x_ready,
  input  logic [FRAC-1:0]          x,
  input  logic [1:0]               mode,
  input  logic                     step_req,
  output logic [FRAC+1:0]          r,
  output logic                     r_changed,
  output logic                     settling,
  output logic                     wr_en,
  output logic [$clog2(N_OSC)-1:0] wr_idx,
  output logic [FRAC-1:0]          wr_x
);

  localparam int IDX_W = $clog2(N_OSC);
  localparam int SET_W = $clog2(SETTLE + 1);
  localparam int DWL_W = $clog2(DWELL + 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_OSC - 1);
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE - 1);
  localparam logic [DWL_W-1:0] DWL_LAST = DWL_W'(DWELL - 1);

  state_e            state;
  logic              dir;
  logic [SET_W-1:0]  settle_cnt;
  logic [DWL_W-1:0]  dwell_cnt;
  logic [IDX_W-1:0]  idx;
  logic [FRAC+1:0]   r_next;
  logic              dir_next;
  logic              man_step;
  logic              auto_step;

  logs_r_stepper #(
    .FRAC        (FRAC),
    .R_MIN       (R_MIN),
    .R_MAX       (R_MAX),
    .STEP_COARSE (STEP_COARSE),
    .STEP_FINE   (STEP_FINE)
  ) u_stepper (
    .r        (r),
    .dir      (dir),
    .mode     (mode),
    .r_next   (r_next),
    .dir_next (dir_next)
  );

  // A manual step pre-empts any coincident x sample.
  assign man_step  = (mode == MODE_MAN) && step_req;
  assign auto_step = (mode == MODE_UP) || (mode == MODE_PP);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_SETTLE;
      r          <= (FRAC+2)'(R_MIN);
      dir        <= 1'b0;
      settle_cnt <= '0;
      dwell_cnt  <= '0;
      idx        <= '0;
      r_changed  <= 1'b0;
      settling   <= 1'b1;
      wr_en      <= 1'b0;
      wr_idx     <= '0;
      wr_x       <= '0;
    end else begin
      wr_en     <= 1'b0;
      r_changed <= 1'b0;
      if (man_step) begin
        r          <= r_next;
        dir        <= dir_next;
        r_changed  <= 1'b1;
        state      <= ST_SETTLE;
        settling   <= 1'b1;
        settle_cnt <= '0;
        dwell_cnt  <= '0;
      end else if (x_ready) begin
        if (state == ST_SETTLE) begin
          if (settle_cnt == SET_LAST) begin
            state      <= ST_PLAY;
            settling   <= 1'b0;
            settle_cnt <= '0;
            dwell_cnt  <= '0;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end else begin
          wr_en  <= 1'b1;
          wr_x   <= x;
          wr_idx <= idx;
          idx    <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
          if (dwell_cnt == DWL_LAST) begin
            dwell_cnt <= '0;
            // Hold and manual modes keep playing the same r.
            if (auto_step) begin
              r          <= r_next;
              dir        <= dir_next;
              r_changed  <= 1'b1;
              state      <= ST_SETTLE;
              settling   <= 1'b1;
              settle_cnt <= '0;
            end
          end else begin
            dwell_cnt <= dwell_cnt + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_logs_r_sequencer.sv
module tb_logs_r_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       x_ready = 1'b0;
  logic [7:0] x = '0;
  logic [1:0] mode = 2'b00;
  logic       step_req = 1'b0;

  logic [9:0] r_a, r_b, r_c, r_d;
  logic       rc_a, rc_b, rc_c, rc_d;
  logic       st_a, st_b, st_c, st_d;
  logic       we_a, we_b, we_c, we_d;
  logic [1:0] wi_a, wi_b, wi_c, wi_d;
  logic [7:0] wx_a, wx_b, wx_c, wx_d;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // A: default bounds; B: low ceiling; C: coarse/fine boundary; D: top-of-range wrap.
  logs_r_sequencer #(.N_OSC(3), .DWELL(3), .SETTLE(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .x_ready(x_ready), .x(x), .mode(mode), .step_req(step_req),
    .r(r_a), .r_changed(rc_a), .settling(st_a), .wr_en(we_a), .wr_idx(wi_a), .wr_x(wx_a));
  logs_r_sequencer #(.N_OSC(3), .DWELL(3), .SETTLE(4), .R_MAX('h118)) dut_b (
    .clk(clk), .rst_n(rst_n), .x_ready(x_ready), .x(x), .mode(mode), .step_req(step_req),
    .r(r_b), .r_changed(rc_b), .settling(st_b), .wr_en(we_b), .wr_idx(wi_b), .wr_x(wx_b));
  logs_r_sequencer #(.N_OSC(3), .DWELL(3), .SETTLE(4), .R_MIN('h2FC)) dut_c (
    .clk(clk), .rst_n(rst_n), .x_ready(x_ready), .x(x), .mode(mode), .step_req(step_req),
    .r(r_c), .r_changed(rc_c), .settling(st_c), .wr_en(we_c), .wr_idx(wi_c), .wr_x(wx_c));
  logs_r_sequencer #(.N_OSC(3), .DWELL(3), .SETTLE(4), .R_MIN('h3FE)) dut_d (
    .clk(clk), .rst_n(rst_n), .x_ready(x_ready), .x(x), .mode(mode), .step_req(step_req),
    .r(r_d), .r_changed(rc_d), .settling(st_d), .wr_en(we_d), .wr_idx(wi_d), .wr_x(wx_d));

  task automatic do_reset(input logic [1:0] m);
    rst_n = 1'b0; x_ready = 1'b0; step_req = 1'b0; mode = m;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Drives one x_ready pulse; returns #1 after the edge that sampled it.
  task automatic send_x(input logic [7:0] v);
    x_ready = 1'b1; x = v;
    @(posedge clk);
    #1 x_ready = 1'b0;
  endtask

  // One full dwell: SETTLE=4 discarded + DWELL=3 played samples.
  task automatic run_dwell();
    for (int i = 0; i < 7; i++) send_x(8'(i + 1));
  endtask

  task automatic test_reset();
    do_reset(2'b00);
    n_vec++; if (r_a !== 10'h110) begin n_err++; $display("FAIL reset_r got %h want 110", r_a); end
    n_vec++; if (st_a !== 1'b1) begin n_err++; $display("FAIL reset_settling got %b want 1", st_a); end
    n_vec++; if (we_a !== 1'b0) begin n_err++; $display("FAIL reset_wr_en got %b want 0", we_a); end
    n_vec++; if (wi_a !== 2'd0) begin n_err++; $display("FAIL reset_wr_idx got %0d want 0", wi_a); end
    n_vec++; if (rc_a !== 1'b0) begin n_err++; $display("FAIL reset_r_changed got %b want 0", rc_a); end
  endtask

  task automatic test_settle_play();
    do_reset(2'b00);
    for (int i = 0; i < 4; i++) begin
      send_x(8'(10 * (i + 1)));
      n_vec++; if (we_a !== 1'b0) begin n_err++; $display("FAIL settle_no_wr[%0d] got %b want 0", i, we_a); end
    end
    n_vec++; if (st_a !== 1'b0) begin n_err++; $display("FAIL settle_exit got %b want 0", st_a); end
    for (int k = 0; k < 3; k++) begin
      send_x(8'(50 + 10 * k));
      n_vec++; if (we_a !== 1'b1) begin n_err++; $display("FAIL play_wr_en[%0d] got %b want 1", k, we_a); end
      n_vec++; if (wi_a !== 2'(k)) begin n_err++; $display("FAIL play_wr_idx[%0d] got %0d want %0d", k, wi_a, k); end
      n_vec++; if (wx_a !== 8'(50 + 10 * k)) begin n_err++; $display("FAIL play_wr_x[%0d] got %0d want %0d", k, wx_a, 50 + 10 * k); end
      if (k < 2) begin
        n_vec++; if (rc_a !== 1'b0) begin n_err++; $display("FAIL play_rc_early[%0d] got %b want 0", k, rc_a); end
      end
    end
    n_vec++; if (r_a !== 10'h114) begin n_err++; $display("FAIL dwell_end_r got %h want 114", r_a); end
    n_vec++; if (rc_a !== 1'b1) begin n_err++; $display("FAIL dwell_end_rc got %b want 1", rc_a); end
    n_vec++; if (st_a !== 1'b1) begin n_err++; $display("FAIL dwell_end_settling got %b want 1", st_a); end
    @(posedge clk); #1;
    n_vec++; if (we_a !== 1'b0) begin n_err++; $display("FAIL wr_en_pulse got %b want 0", we_a); end
    n_vec++; if (rc_a !== 1'b0) begin n_err++; $display("FAIL rc_pulse got %b want 0", rc_a); end
  endtask

  task automatic test_sweep_wrap();
    logic [9:0] exp_r [3];
    exp_r = '{10'h114, 10'h118, 10'h110};
    do_reset(2'b00);
    for (int d = 0; d < 3; d++) begin
      run_dwell();
      n_vec++; if (r_b !== exp_r[d]) begin n_err++; $display("FAIL wrap_r[%0d] got %h want %h", d, r_b, exp_r[d]); end
    end
  endtask

  task automatic test_ping_pong();
    logic [9:0] exp_r [5];
    exp_r = '{10'h114, 10'h118, 10'h114, 10'h110, 10'h114};
    do_reset(2'b01);
    for (int d = 0; d < 5; d++) begin
      run_dwell();
      n_vec++; if (r_b !== exp_r[d]) begin n_err++; $display("FAIL pp_r[%0d] got %h want %h", d, r_b, exp_r[d]); end
    end
  endtask

  task automatic test_step_size();
    logic [9:0] exp_c [3];
    logic [9:0] exp_d [2];
    exp_c = '{10'h300, 10'h301, 10'h302};
    exp_d = '{10'h3FF, 10'h3FE};
    do_reset(2'b00);
    n_vec++; if (r_c !== 10'h2FC) begin n_err++; $display("FAIL step_c_init got %h want 2fc", r_c); end
    for (int d = 0; d < 3; d++) begin
      run_dwell();
      n_vec++; if (r_c !== exp_c[d]) begin n_err++; $display("FAIL step_c[%0d] got %h want %h", d, r_c, exp_c[d]); end
      if (d < 2) begin
        n_vec++; if (r_d !== exp_d[d]) begin n_err++; $display("FAIL step_d[%0d] got %h want %h", d, r_d, exp_d[d]); end
      end
    end
  endtask

  task automatic test_manual_hold();
    do_reset(2'b11);
    run_dwell();
    n_vec++; if (r_a !== 10'h110) begin n_err++; $display("FAIL man_dwell_r got %h want 110", r_a); end
    n_vec++; if (st_a !== 1'b0) begin n_err++; $display("FAIL man_dwell_settling got %b want 0", st_a); end
    for (int k = 0; k < 2; k++) begin
      send_x(8'(100 + k));
      n_vec++; if (we_a !== 1'b1 || wi_a !== 2'(k)) begin
        n_err++; $display("FAIL man_idx_wrap[%0d] got en=%b idx=%0d want en=1 idx=%0d", k, we_a, wi_a, k);
      end
    end
    x_ready = 1'b1; x = 8'd200; step_req = 1'b1;
    @(posedge clk);
    #1 x_ready = 1'b0; step_req = 1'b0;
    n_vec++; if (r_a !== 10'h114) begin n_err++; $display("FAIL man_step_r got %h want 114", r_a); end
    n_vec++; if (st_a !== 1'b1) begin n_err++; $display("FAIL man_step_settling got %b want 1", st_a); end
    n_vec++; if (we_a !== 1'b0) begin n_err++; $display("FAIL man_step_wr_en got %b want 0", we_a); end
    n_vec++; if (rc_a !== 1'b1) begin n_err++; $display("FAIL man_step_rc got %b want 1", rc_a); end
    do_reset(2'b10);
    step_req = 1'b1;
    @(posedge clk);
    #1 step_req = 1'b0;
    n_vec++; if (r_a !== 10'h110 || rc_a !== 1'b0) begin
      n_err++; $display("FAIL hold_step_ignored got r=%h rc=%b want r=110 rc=0", r_a, rc_a);
    end
    run_dwell();
    n_vec++; if (r_a !== 10'h110 || st_a !== 1'b0) begin
      n_err++; $display("FAIL hold_dwell got r=%h settling=%b want r=110 settling=0", r_a, st_a);
    end
  endtask

  task automatic test_reset_mid_play();
    do_reset(2'b00);
    for (int i = 0; i < 6; i++) send_x(8'(40 + i));
    x_ready = 1'b1; x = 8'd99; rst_n = 1'b0;
    @(posedge clk);
    #1 x_ready = 1'b0; rst_n = 1'b1;
    n_vec++; if (we_a !== 1'b0) begin n_err++; $display("FAIL rst_mid_wr_en got %b want 0", we_a); end
    n_vec++; if (wi_a !== 2'd0 || wx_a !== 8'd0) begin
      n_err++; $display("FAIL rst_mid_wr got idx=%0d x=%0d want idx=0 x=0", wi_a, wx_a);
    end
    n_vec++; if (r_a !== 10'h110 || st_a !== 1'b1 || rc_a !== 1'b0) begin
      n_err++; $display("FAIL rst_mid_state got r=%h settling=%b rc=%b want r=110 settling=1 rc=0", r_a, st_a, rc_a);
    end
    send_x(8'd1);
    n_vec++; if (we_a !== 1'b0) begin n_err++; $display("FAIL rst_mid_resettle got %b want 0", we_a); end
  endtask

  initial begin
    test_reset();
    test_settle_play();
    test_sweep_wrap();
    test_ping_pong();
    test_step_size();
    test_manual_hold();
    test_reset_mid_play();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
